// File: rtl/escalonador_fuzzy_if.sv
// Signal bundle between the fuzzy-core scheduler, the channel front-ends,
// the shared fuzzy core and the result consumer.
interface escalonador_fuzzy_if #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
);
    logic [N_CH-1:0]   req;
    logic [8*N_CH-1:0] ent_01;
    logic [8*N_CH-1:0] ent_02;
    logic [N_CH-1:0]   ack;
    logic [7:0]        core_ent_01;
    logic [7:0]        core_ent_02;
    logic              core_clr;
    logic              core_en_regras;
    logic [7:0]        core_saida;
    logic              res_valid;
    logic              res_ready;
    logic [CH_W-1:0]   res_canal;
    logic [7:0]        res_dado;
    logic              busy;

    // slave: the scheduler; master: everything around it
    modport slave (
        input  req, ent_01, ent_02, core_saida, res_ready,
        output ack, core_ent_01, core_ent_02, core_clr, core_en_regras,
               res_valid, res_canal, res_dado, busy
    );

    modport master (
        output req, ent_01, ent_02, core_saida, res_ready,
        input  ack, core_ent_01, core_ent_02, core_clr, core_en_regras,
               res_valid, res_canal, res_dado, busy
    );
endinterface

// File: rtl/escalonador_fuzzy.sv
// Round-robin scheduler time-sharing one type-2 fuzzy core among N_CH channels:
// grant, clear core, hold EN_REGRAS for LAT cycles, return tagged result.
module escalonador_fuzzy #(
    parameter int N_CH = 4,
    parameter int CH_W = 2,
    parameter int LAT  = 20
) (
    input  logic clk_0,
    input  logic Srst,
    escalonador_fuzzy_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      ent01_q, ent01_d;
    logic [7:0]      ent02_q, ent02_d;
    logic [7:0]      dado_q, dado_d;
    logic [CH_W-1:0] canal_q, canal_d;
    logic [N_CH-1:0] ack_q, ack_d;
    logic            clr_q, en_q, valid_q, busy_q;

    logic            win_found;
    logic [CH_W-1:0] win_idx;
    logic [CH_W-1:0] cand;

    // Search starts just after the last served channel; index wraps for free
    // because N_CH is a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = ptr_q + CH_W'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ent01_d = ent01_q;
        ent02_d = ent02_q;
        dado_d  = dado_q;
        canal_d = canal_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = LOAD;
                    ent01_d = bus.ent_01[8*win_idx +: 8];
                    ent02_d = bus.ent_02[8*win_idx +: 8];
                    canal_d = win_idx;
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = 8'(LAT - 1);
            end
            RUN: begin
                if (cnt_q == 8'd0) begin
                    dado_d  = bus.core_saida;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    ptr_d   = canal_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant pulse is decoded from the next state so it appears during LOAD.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ack
        assign ack_d[gi] = (state_d == LOAD) && (win_idx == CH_W'(gi));
    end

    always_ff @(posedge clk_0 or negedge Srst) begin
        if (!Srst) begin
            state_q <= IDLE;
            ptr_q   <= CH_W'(N_CH - 1);
            cnt_q   <= '0;
            ent01_q <= '0;
            ent02_q <= '0;
            dado_q  <= '0;
            canal_q <= '0;
            ack_q   <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ent01_q <= ent01_d;
            ent02_q <= ent02_d;
            dado_q  <= dado_d;
            canal_q <= canal_d;
            ack_q   <= ack_d;
            clr_q   <= (state_d == LOAD);
            en_q    <= (state_d == RUN);
            valid_q <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.ack            = ack_q;
    assign bus.core_ent_01    = ent01_q;
    assign bus.core_ent_02    = ent02_q;
    assign bus.core_clr       = clr_q;
    assign bus.core_en_regras = en_q;
    assign bus.res_valid      = valid_q;
    assign bus.res_canal      = canal_q;
    assign bus.res_dado       = dado_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_escalonador_fuzzy.sv
// Two scheduler instances (LAT=20 and LAT=1) checked every cycle against a
// transaction-timeline model, plus directed scenarios with literal expectations.
module tb_escalonador_fuzzy;
    localparam int N_CH = 4;
    localparam int CH_W = 2;

    logic clk_0 = 1'b0;
    logic Srst  = 1'b0;
    always #5 clk_0 = ~clk_0;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int edge_n   = 0;
    always @(posedge clk_0) edge_n <= edge_n + 1;

    logic [N_CH-1:0]   req_drv    [2];
    logic [8*N_CH-1:0] ent1_drv   [2];
    logic [8*N_CH-1:0] ent2_drv   [2];
    logic [7:0]        saida_drv  [2];
    logic              ready_drv  [2];
    logic [N_CH-1:0]   rise_mask  [2];
    int                rise_pct   [2];
    int                saida_mode [2];
    bit                ready_rand [2];

    logic [N_CH-1:0] ack_obs   [2];
    logic            clr_obs   [2];
    logic            en_obs    [2];
    logic            valid_obs [2];
    logic            busy_obs  [2];
    logic [7:0]      c1_obs    [2];
    logic [7:0]      c2_obs    [2];
    logic [7:0]      dado_obs  [2];
    logic [CH_W-1:0] canal_obs [2];

    escalonador_fuzzy_if #(.N_CH(N_CH), .CH_W(CH_W)) if0 ();
    escalonador_fuzzy_if #(.N_CH(N_CH), .CH_W(CH_W)) if1 ();

    escalonador_fuzzy #(.N_CH(N_CH), .CH_W(CH_W), .LAT(20)) dut0 (
        .clk_0(clk_0), .Srst(Srst), .bus(if0.slave));
    escalonador_fuzzy #(.N_CH(N_CH), .CH_W(CH_W), .LAT(1)) dut1 (
        .clk_0(clk_0), .Srst(Srst), .bus(if1.slave));

    assign if0.req = req_drv[0];          assign if1.req = req_drv[1];
    assign if0.ent_01 = ent1_drv[0];      assign if1.ent_01 = ent1_drv[1];
    assign if0.ent_02 = ent2_drv[0];      assign if1.ent_02 = ent2_drv[1];
    assign if0.core_saida = saida_drv[0]; assign if1.core_saida = saida_drv[1];
    assign if0.res_ready = ready_drv[0];  assign if1.res_ready = ready_drv[1];

    assign ack_obs[0]   = if0.ack;            assign ack_obs[1]   = if1.ack;
    assign clr_obs[0]   = if0.core_clr;       assign clr_obs[1]   = if1.core_clr;
    assign en_obs[0]    = if0.core_en_regras; assign en_obs[1]    = if1.core_en_regras;
    assign valid_obs[0] = if0.res_valid;      assign valid_obs[1] = if1.res_valid;
    assign busy_obs[0]  = if0.busy;           assign busy_obs[1]  = if1.busy;
    assign c1_obs[0]    = if0.core_ent_01;    assign c1_obs[1]    = if1.core_ent_01;
    assign c2_obs[0]    = if0.core_ent_02;    assign c2_obs[1]    = if1.core_ent_02;
    assign dado_obs[0]  = if0.res_dado;       assign dado_obs[1]  = if1.res_dado;
    assign canal_obs[0] = if0.res_canal;      assign canal_obs[1] = if1.res_canal;

    function automatic int lat_of(input int l);
        return (l == 0) ? 20 : 1;
    endfunction

    // Cyclic search from the channel after the last served one.
    function automatic int rr_pick(input logic [N_CH-1:0] r, input int p);
        for (int s = 1; s <= N_CH; s++) begin
            if (r[(p + s) % N_CH]) return (p + s) % N_CH;
        end
        return 0;
    endfunction

    function automatic int onehot_idx(input logic [N_CH-1:0] v);
        for (int c = 0; c < N_CH; c++) if (v[c]) return c;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: each transaction is a timeline counted in edges since the grant
    // edge (k). k=0: grant pulse; 1..LAT: rules enabled; LAT+1: result waiting.
    bit         m_active [2];
    int         m_k      [2];
    int         m_canal  [2];
    int         m_ptr    [2];
    logic [7:0] m_ent1   [2];
    logic [7:0] m_ent2   [2];
    logic [7:0] m_dado   [2];

    always @(posedge clk_0 or negedge Srst) begin
        for (int l = 0; l < 2; l++) begin
            if (!Srst) begin
                m_active[l] <= 1'b0; m_k[l] <= 0; m_canal[l] <= 0; m_ptr[l] <= N_CH - 1;
                m_ent1[l] <= '0; m_ent2[l] <= '0; m_dado[l] <= '0;
            end else if (!m_active[l]) begin
                if (req_drv[l] != '0) begin
                    m_active[l] <= 1'b1;
                    m_k[l]      <= 0;
                    m_canal[l]  <= rr_pick(req_drv[l], m_ptr[l]);
                    m_ent1[l]   <= ent1_drv[l][8*rr_pick(req_drv[l], m_ptr[l]) +: 8];
                    m_ent2[l]   <= ent2_drv[l][8*rr_pick(req_drv[l], m_ptr[l]) +: 8];
                end
            end else if (m_k[l] <= lat_of(l)) begin
                m_k[l] <= m_k[l] + 1;
                if (m_k[l] == lat_of(l)) m_dado[l] <= saida_drv[l];
            end else if (ready_drv[l]) begin
                m_active[l] <= 1'b0;
                m_ptr[l]    <= m_canal[l];
            end
        end
    end

    task automatic compare_lane(input int l);
        int L;
        bit a;
        int k;
        logic [N_CH-1:0] e_ack;
        L = lat_of(l);
        a = m_active[l];
        k = m_k[l];
        e_ack = '0;
        if (a && k == 0) e_ack[m_canal[l]] = 1'b1;
        chk($sformatf("L%0d ack", l), 32'(ack_obs[l]), 32'(e_ack));
        chk($sformatf("L%0d core_clr", l), 32'(clr_obs[l]), 32'(a && k == 0));
        chk($sformatf("L%0d core_en_regras", l), 32'(en_obs[l]), 32'(a && k >= 1 && k <= L));
        chk($sformatf("L%0d res_valid", l), 32'(valid_obs[l]), 32'(a && k == L + 1));
        chk($sformatf("L%0d busy", l), 32'(busy_obs[l]), 32'(a));
        chk($sformatf("L%0d core_ent_01", l), 32'(c1_obs[l]), 32'(m_ent1[l]));
        chk($sformatf("L%0d core_ent_02", l), 32'(c2_obs[l]), 32'(m_ent2[l]));
        chk($sformatf("L%0d res_canal", l), 32'(canal_obs[l]), 32'(m_canal[l]));
        chk($sformatf("L%0d res_dado", l), 32'(dado_obs[l]), 32'(m_dado[l]));
    endtask

    always @(negedge clk_0) begin
        if (chk_en) begin
            compare_lane(0);
            compare_lane(1);
        end
    end

    // Requesters: drop on grant, optionally re-raise with fresh data.
    always @(negedge clk_0) begin
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (req_drv[l][c] && m_active[l] && m_k[l] == 0 && m_canal[l] == c) begin
                    req_drv[l][c] = 1'b0;
                end else if (!req_drv[l][c] && rise_mask[l][c] &&
                             int'($urandom_range(99)) < rise_pct[l]) begin
                    ent1_drv[l][8*c +: 8] = 8'($urandom);
                    ent2_drv[l][8*c +: 8] = 8'($urandom);
                    req_drv[l][c] = 1'b1;
                end
            end
            if (saida_mode[l] == 1) saida_drv[l] = 8'($urandom);
            else if (saida_mode[l] == 2) saida_drv[l] = 8'(edge_n * 7 + 3);
            if (ready_rand[l]) ready_drv[l] = (int'($urandom_range(99)) < 70);
        end
    end

    // Event log taken from the DUT pins for the directed timing checks.
    int grant_cnt [2];
    int valid_cnt [2];
    int ack_len   [2];
    int en_len    [2];
    int gch       [2][32];
    int gedge     [2][32];
    int last_valid_edge [2];
    int last_en         [2];
    int last_ack_len    [2];
    logic [N_CH-1:0] last_ack_val [2];
    bit prev_ack_any [2];
    bit prev_valid   [2];

    always @(negedge clk_0) begin
        for (int l = 0; l < 2; l++) begin
            if (ack_obs[l] != '0) begin
                if (!prev_ack_any[l]) begin
                    gch[l][grant_cnt[l] % 32]   = onehot_idx(ack_obs[l]);
                    gedge[l][grant_cnt[l] % 32] = edge_n;
                    grant_cnt[l]++;
                    ack_len[l] = 0;
                    en_len[l]  = 0;
                    last_ack_val[l] = ack_obs[l];
                end
                ack_len[l]++;
            end
            if (en_obs[l] === 1'b1) en_len[l]++;
            if (valid_obs[l] === 1'b1 && !prev_valid[l]) begin
                valid_cnt[l]++;
                last_valid_edge[l] = edge_n;
                last_en[l]         = en_len[l];
                last_ack_len[l]    = ack_len[l];
            end
            prev_ack_any[l] = (ack_obs[l] != '0);
            prev_valid[l]   = (valid_obs[l] === 1'b1);
        end
    end

    task automatic tick();
        @(negedge clk_0);
        #1;
    endtask

    task automatic wait_grants(input int l, input int target, input int budget);
        int n = 0;
        while (grant_cnt[l] < target && n < budget) begin tick(); n++; end
        chk($sformatf("L%0d grant timeout", l), 32'(grant_cnt[l] >= target), 32'd1);
    endtask

    task automatic wait_valid(input int l, input int target, input int budget);
        int n = 0;
        while (valid_cnt[l] < target && n < budget) begin tick(); n++; end
        chk($sformatf("L%0d valid timeout", l), 32'(valid_cnt[l] >= target), 32'd1);
    endtask

    task automatic wait_idle(input int l, input int budget);
        int n = 0;
        while (!(req_drv[l] == '0 && busy_obs[l] == 1'b0) && n < budget) begin tick(); n++; end
        chk($sformatf("L%0d idle timeout", l), 32'(req_drv[l] == '0 && busy_obs[l] == 1'b0), 32'd1);
    endtask

    task automatic chk_zero(input int l, input string tag);
        chk({tag, " ack"}, 32'(ack_obs[l]), 32'd0);
        chk({tag, " clr"}, 32'(clr_obs[l]), 32'd0);
        chk({tag, " en_regras"}, 32'(en_obs[l]), 32'd0);
        chk({tag, " valid"}, 32'(valid_obs[l]), 32'd0);
        chk({tag, " busy"}, 32'(busy_obs[l]), 32'd0);
        chk({tag, " ent01"}, 32'(c1_obs[l]), 32'd0);
        chk({tag, " ent02"}, 32'(c2_obs[l]), 32'd0);
        chk({tag, " canal"}, 32'(canal_obs[l]), 32'd0);
        chk({tag, " dado"}, 32'(dado_obs[l]), 32'd0);
    endtask

    initial begin
        int g, ge, ve, v, rel;
        logic [7:0] bp_dado;
        for (int l = 0; l < 2; l++) begin
            req_drv[l] = '0; ent1_drv[l] = '0; ent2_drv[l] = '0; saida_drv[l] = '0;
            ready_drv[l] = 1'b1; rise_mask[l] = '0; rise_pct[l] = 0; saida_mode[l] = 0;
            ready_rand[l] = 1'b0; grant_cnt[l] = 0; valid_cnt[l] = 0; ack_len[l] = 0;
            en_len[l] = 0; last_valid_edge[l] = 0; last_en[l] = 0; last_ack_len[l] = 0;
            last_ack_val[l] = '0; prev_ack_any[l] = 1'b0; prev_valid[l] = 1'b0;
        end
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        chk_zero(0, "reset L0");
        chk_zero(1, "reset L1");
        Srst = 1'b1;
        tick();

        // Single request on ch1, LAT=20, core returns 0x5C.
        saida_drv[0] = 8'h5C; ready_drv[0] = 1'b0;
        ent1_drv[0][15:8] = 8'h40; ent2_drv[0][15:8] = 8'hA0;
        req_drv[0] = 4'b0010;
        wait_valid(0, valid_cnt[0] + 1, 60);
        ge = gedge[0][(grant_cnt[0] - 1) % 32];
        chk("T1 ack value", 32'(last_ack_val[0]), 32'h2);
        chk("T1 ack cycles", 32'(last_ack_len[0]), 32'd1);
        chk("T1 core_ent_01", 32'(c1_obs[0]), 32'h40);
        chk("T1 core_ent_02", 32'(c2_obs[0]), 32'hA0);
        chk("T1 en cycles", 32'(last_en[0]), 32'd20);
        chk("T1 valid latency", 32'(last_valid_edge[0] - ge), 32'd21);
        chk("T1 res_canal", 32'(canal_obs[0]), 32'd1);
        chk("T1 res_dado", 32'(dado_obs[0]), 32'h5C);
        ready_drv[0] = 1'b1;
        wait_idle(0, 20);

        // Fairness from reset: 0,1,2,3,0 spaced LAT+3 edges.
        Srst = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            ent1_drv[0][8*c +: 8] = 8'($urandom);
            ent2_drv[0][8*c +: 8] = 8'($urandom);
        end
        req_drv[0] = 4'b1111;
        tick();
        Srst = 1'b1;
        g = grant_cnt[0];
        rise_mask[0] = 4'b1111; rise_pct[0] = 100; saida_mode[0] = 1;
        wait_grants(0, g + 5, 200);
        for (int i = 0; i < 5; i++)
            chk($sformatf("T2 order[%0d]", i), 32'(gch[0][(g + i) % 32]), 32'(i % 4));
        for (int i = 1; i < 5; i++)
            chk($sformatf("T2 spacing[%0d]", i),
                32'(gedge[0][(g + i) % 32] - gedge[0][(g + i - 1) % 32]), 32'd23);
        rise_pct[0] = 0;
        wait_idle(0, 200);

        // Backpressure with ch3 pending again while the result waits.
        ready_drv[0] = 1'b0; rise_mask[0] = 4'b1000; rise_pct[0] = 100;
        wait_valid(0, valid_cnt[0] + 1, 60);
        bp_dado = m_dado[0];
        repeat (50) begin
            tick();
            chk("T3 valid held", 32'(valid_obs[0]), 32'd1);
            chk("T3 canal held", 32'(canal_obs[0]), 32'd3);
            chk("T3 dado held", 32'(dado_obs[0]), 32'(bp_dado));
            chk("T3 no ack", 32'(ack_obs[0]), 32'd0);
            chk("T3 en low", 32'(en_obs[0]), 32'd0);
        end
        g = grant_cnt[0];
        ready_drv[0] = 1'b1; rise_pct[0] = 0;
        rel = edge_n;
        wait_grants(0, g + 1, 10);
        chk("T3 next grant ch", 32'(gch[0][g % 32]), 32'd3);
        chk("T3 next grant edge", 32'(gedge[0][g % 32] - rel), 32'd2);
        wait_idle(0, 60);

        // Reset during RUN cycle 7.
        ent1_drv[0][23:16] = 8'($urandom); ent2_drv[0][23:16] = 8'($urandom);
        req_drv[0] = 4'b0100;
        g = grant_cnt[0];
        wait_grants(0, g + 1, 10);
        ge = gedge[0][g % 32];
        for (int n = 0; n < 20 && edge_n < ge + 7; n++) tick();
        v = valid_cnt[0];
        Srst = 1'b0;
        #1;
        chk_zero(0, "T4 async");
        ent1_drv[0][15:8] = 8'($urandom); ent2_drv[0][15:8] = 8'($urandom);
        req_drv[0] = 4'b0110;
        tick();
        Srst = 1'b1;
        g = grant_cnt[0];
        wait_grants(0, g + 1, 10);
        chk("T4 first grant", 32'(gch[0][g % 32]), 32'd1);
        chk("T4 no result", 32'(valid_cnt[0]), 32'(v));
        wait_idle(0, 100);

        // Late request raised during ch0 RUN.
        ent1_drv[0][7:0] = 8'($urandom); ent2_drv[0][7:0] = 8'($urandom);
        req_drv[0] = 4'b0001;
        g = grant_cnt[0];
        wait_grants(0, g + 1, 10);
        repeat (5) tick();
        ent1_drv[0][23:16] = 8'($urandom); ent2_drv[0][23:16] = 8'($urandom);
        req_drv[0][2] = 1'b1;
        wait_valid(0, valid_cnt[0] + 1, 40);
        ve = last_valid_edge[0];
        wait_grants(0, g + 2, 10);
        chk("T5 late grant ch", 32'(gch[0][(g + 1) % 32]), 32'd2);
        chk("T5 late grant edge", 32'(gedge[0][(g + 1) % 32] - ve), 32'd2);
        wait_idle(0, 60);

        // LAT=1 corner on the second instance.
        saida_mode[1] = 2;
        ent1_drv[1][23:16] = 8'h11; ent2_drv[1][23:16] = 8'h22;
        req_drv[1] = 4'b0100;
        wait_valid(1, valid_cnt[1] + 1, 20);
        ge = gedge[1][(grant_cnt[1] - 1) % 32];
        chk("T6 en cycles", 32'(last_en[1]), 32'd1);
        chk("T6 valid latency", 32'(last_valid_edge[1] - ge), 32'd2);
        chk("T6 canal", 32'(canal_obs[1]), 32'd2);
        chk("T6 ent01", 32'(c1_obs[1]), 32'h11);
        chk("T6 dado", 32'(dado_obs[1]), 32'(8'((ge + 1) * 7 + 3)));
        wait_idle(1, 20);

        // Random traffic on both instances.
        for (int l = 0; l < 2; l++) begin
            rise_mask[l] = 4'b1111; rise_pct[l] = 25; ready_rand[l] = 1'b1; saida_mode[l] = 1;
        end
        repeat (3000) tick();
        for (int l = 0; l < 2; l++) begin
            rise_pct[l] = 0; ready_rand[l] = 1'b0; ready_drv[l] = 1'b1;
        end
        wait_idle(0, 300);
        wait_idle(1, 300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/escalonador_fuzzy.md
# escalonador_fuzzy

Round-robin scheduler that time-shares one type-2 fuzzy controller core among `N_CH` sensor channels. Each channel supplies an input pair; the scheduler grants one channel at a time and clears the core. It then drives the pair into the core, holds `EN_REGRAS` for a fixed rule/defuzzify window, and captures the defuzzified output. It returns the result, tagged with its channel number, through a valid/ready handshake. It sits between the channel front-ends and the fuzzy core top.

## Interface
- `N_CH`, default 4, number of channels; must be a power of two, 2..8.
- `CH_W`, default 2, channel index width, equal to log2(`N_CH`).
- `LAT`, default 20, number of cycles `core_en_regras` is held per computation; range 1..255.
- `clk_0`  in  1  system clock; all flops are rising-edge.
- `Srst`  in  1  asynchronous, active-low reset.
- `req`  in  N_CH  per-channel request; must stay high until the channel's `ack` is seen.
- `ent_01`  in  8*N_CH  first input per channel; channel k occupies bits [8k+7:8k].
- `ent_02`  in  8*N_CH  second input per channel, packed the same way.
- `ack`  out  N_CH  one-hot, one-cycle grant pulse.
- `core_ent_01`  out  8  to core `Entrada_01`; registered.
- `core_ent_02`  out  8  to core `Entrada_02`; registered.
- `core_clr`  out  1  one-cycle clear pulse to the core's inference memory.
- `core_en_regras`  out  1  to core `EN_REGRAS`.
- `core_saida`  in  8  from core `saida_defuzzy`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_canal`  out  CH_W  channel index of the current result.
- `res_dado`  out  8  captured defuzzified value.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, LOAD, RUN and DONE.
- **IDLE**
  - If `req` != 0, the winner is the first set bit searched cyclically from `ptr+1` upward.
  - On the same edge: latch the winner's `ent_01`/`ent_02` slices into `core_ent_01`/`core_ent_02`, set `res_canal` to the winner, and go to LOAD.
  - If `req` == 0, stay in IDLE.
- **LOAD** (exactly 1 cycle)
  - `ack[winner]` = 1 and `core_clr` = 1.
  - Next state is RUN, with `cnt` loaded with LAT-1.
- **RUN**
  - `core_en_regras` = 1 for every RUN cycle.
  - `cnt` decrements each cycle.
  - When `cnt` == 0: capture `core_saida` into `res_dado` and go to DONE.
- **DONE**
  - `res_valid` = 1.
  - When `res_ready` = 1: set `ptr` to `res_canal` and go to IDLE.
  - `res_dado` and `res_canal` hold stable while `res_valid` = 1 and `res_ready` = 0.
- `ack`, `core_clr`, `core_en_regras`, `res_valid` and `busy` are registered decodes of the state and have no combinational path from inputs.
- `req` is sampled only in IDLE. Requests arriving in LOAD, RUN or DONE wait.
- The requester must hold `ent_*` valid whenever its `req` = 1. It must drop `req` on the cycle after `ack` is seen; a `req` still high in the next IDLE is treated as a new request.
- `core_ent_*` are unchanged outside the IDLE→LOAD edge, so the core sees stable inputs throughout RUN.

## Timing
- Reset (`Srst` = 0, async): state = IDLE, `ptr` = N_CH-1 (channel 0 has first priority), `cnt` = 0.
- Also on reset, all outputs are 0: `ack`, `core_ent_01`, `core_ent_02`, `core_clr`, `core_en_regras`, `res_valid`, `res_canal`, `res_dado` and `busy`.
- Reset asserted mid-RUN or mid-DONE aborts immediately. A pending result is discarded, and `core_en_regras` drops asynchronously.
- Reset deassertion: the first grant is possible on the first rising edge with `Srst` = 1.
- Grant edge E0 (IDLE→LOAD): `ack` and `core_clr` are high during the cycle after E0.
- `core_en_regras` is high for exactly LAT cycles, starting at edge E1.
- `res_valid` rises at edge E(LAT+1). With LAT = 20 that is 21 edges after E0.
- Minimum spacing between consecutive grants is LAT+3 edges, with `res_ready` held at 1.
- `res_ready` = 1 in DONE costs 1 cycle; IDLE then costs ≥1 cycle before the next grant.
- When multiple requests are present, only the round-robin winner receives `ack`; the others remain pending.

## Test plan
- **Single request, LAT = 20.** Stimulus: `req` = 0010, ch1 inputs = 0x40/0xA0, core model returns 0x5C. Required: `ack` = 0010 for 1 cycle at E0+1; `core_ent` = 0x40/0xA0; `core_en_regras` high 20 cycles; `res_valid` at E21 with `res_canal` = 1, `res_dado` = 0x5C.
- **Fairness.** Stimulus: all four `req` held high, re-raised after each `ack`, `res_ready` = 1. Required: grant order 0,1,2,3,0 after reset; consecutive grant edges spaced 23 edges apart.
- **Backpressure.** Stimulus: `res_ready` = 0 for 50 cycles in DONE while `req` = 1000. Required: `res_valid`, `res_dado` and `res_canal` stable; no `ack`; `core_en_regras` = 0. Releasing `res_ready` leads to the ch3 grant 2 edges later.
- **Reset mid-RUN.** Stimulus: `Srst` pulled low at RUN cycle 7. Required: all outputs 0 immediately; no `res_valid`; first post-reset grant goes to the lowest set `req`.
- **Late request.** Stimulus: `req[2]` raised during RUN of ch0. Required: ch2 granted on the first IDLE edge after ch0's result is accepted.
- **LAT = 1 corner.** Required: `core_en_regras` high exactly 1 cycle; `res_valid` at E2; `core_saida` sampled on that single RUN cycle.
